// File: rtl/pll_dri_pkg.sv
// Shared types and DRI field layout for the CCC PLL reconfiguration controller.
// Imported by the lock synchronizer and the controller top.
package pll_dri_pkg;

    localparam int DIV_W    = 7;
    localparam int DRI_DW   = 33;
    localparam int CTRL_W   = 11;
    localparam int ADDR_LSB = 3;
    localparam int ADDR_W   = 8;
    localparam int DRI_WR   = 2;
    localparam int DRI_RD   = 1;

    typedef enum logic [2:0] {
        S_BOOT_LOCK,
        S_IDLE,
        S_RD,
        S_RD_WAIT,
        S_WR,
        S_WAIT_UNLOCK,
        S_WAIT_LOCK,
        S_ERR
    } state_e;

    function automatic logic [CTRL_W-1:0] dri_cmd(
        input logic [ADDR_W-1:0] addr,
        input logic              wr,
        input logic              rd
    );
        logic [CTRL_W-1:0] c;
        c = '0;
        c[ADDR_LSB +: ADDR_W] = addr;
        c[DRI_WR] = wr;
        c[DRI_RD] = rd;
        return c;
    endfunction

endpackage

// File: rtl/pll_dri_reconfig_ctrl_lock_sync.sv
// PLL lock synchronizer and stability filter.
// restart_i forces a fresh LOCK_STABLE count after a divider write.
module pll_lock_sync
    import pll_dri_pkg::*;
#(
    parameter int LOCK_STABLE = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic pll_lock_i,
    input  logic restart_i,
    output logic lock_sync_o,
    output logic lock_ok_o
);

    localparam int CNT_W = $clog2(LOCK_STABLE + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_STABLE - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ok_q;

    // Two-flop synchronizer for the asynchronous PLL_LOCK.
    always_ff @(posedge clk) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[0], pll_lock_i};
    end

    // Count consecutive high samples; any low sample or restart drops lock.
    always_ff @(posedge clk) begin
        if (reset || restart_i || !sync_q[1]) begin
            cnt_q <= '0;
            ok_q  <= 1'b0;
        end else begin
            if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_MAX) ok_q <= 1'b1;
        end
    end

    assign lock_sync_o = sync_q[1];
    assign lock_ok_o   = ok_q;

endmodule

// File: rtl/pll_dri_reconfig_ctrl.sv
// Sequences a read-modify-write of the PLL OUT0 divider over DRI and
// holds the fabric in reset until the PLL re-locks.
module pll_dri_reconfig_ctrl
    import pll_dri_pkg::*;
#(
    parameter logic [7:0] DIV0_REG_ADDR = 8'h0C,
    parameter int DIV_LSB      = 8,
    parameter int RD_LATENCY   = 2,
    parameter int LOCK_STABLE  = 64,
    parameter int UNLOCK_WAIT  = 256,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [DIV_W-1:0]  cfg_div,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [DIV_W-1:0]  cur_div,
    input  logic              pll_lock,
    output logic [CTRL_W-1:0] dri_ctrl,
    output logic [DRI_DW-1:0] dri_wdata,
    input  logic [DRI_DW-1:0] dri_rdata,
    output logic              dri_arst_n,
    output logic              fab_rst
);

    localparam int TMR_W = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] T_LOCK = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] T_UNL  = TMR_W'(UNLOCK_WAIT - 1);
    localparam logic [TMR_W-1:0] T_RD   = TMR_W'(RD_LATENCY - 1);
    localparam logic [DRI_DW-1:0] DIV_MASK =
        DRI_DW'({DIV_W{1'b1}}) << DIV_LSB;

    state_e            state_q;
    logic [TMR_W-1:0]  tmr_q;
    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  cur_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DRI_DW-1:0] wdata_q;
    logic              ready_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic              fab_q;
    logic              lock_sync;
    logic              lock_ok;
    logic              unl_exit;

    assign unl_exit = (state_q == S_WAIT_UNLOCK) &&
                      (!lock_sync || tmr_q >= T_UNL);

    pll_lock_sync #(
        .LOCK_STABLE (LOCK_STABLE)
    ) u_lock (
        .clk         (clk),
        .reset       (reset),
        .pll_lock_i  (pll_lock),
        .restart_i   (unl_exit),
        .lock_sync_o (lock_sync),
        .lock_ok_o   (lock_ok)
    );

    // Reconfiguration FSM with registered outputs and per-state timer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_BOOT_LOCK;
            tmr_q   <= '0;
            div_q   <= '0;
            cur_q   <= '0;
            ctrl_q  <= '0;
            wdata_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            fab_q   <= 1'b1;
        end else begin
            done_q <= 1'b0;
            ctrl_q <= '0;
            if (tmr_q != '1) tmr_q <= tmr_q + TMR_W'(1);
            unique case (state_q)
                S_BOOT_LOCK: begin
                    if (lock_ok) begin
                        state_q <= S_IDLE;
                        tmr_q   <= '0;
                        fab_q   <= 1'b0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else if (tmr_q >= T_LOCK) begin
                        state_q <= S_ERR;
                        tmr_q   <= '0;
                        err_q   <= 1'b1;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                S_IDLE, S_ERR: begin
                    if (cfg_valid) begin
                        div_q <= cfg_div;
                        tmr_q <= '0;
                        if (cfg_div == '0) begin
                            done_q <= 1'b1;
                            err_q  <= 1'b1;
                        end else begin
                            state_q <= S_RD;
                            ctrl_q  <= dri_cmd(DIV0_REG_ADDR, 1'b0, 1'b1);
                            err_q   <= 1'b0;
                            ready_q <= 1'b0;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                S_RD: begin
                    state_q <= S_RD_WAIT;
                    tmr_q   <= '0;
                end
                S_RD_WAIT: begin
                    if (tmr_q >= T_RD) begin
                        state_q <= S_WR;
                        tmr_q   <= '0;
                        ctrl_q  <= dri_cmd(DIV0_REG_ADDR, 1'b1, 1'b0);
                        wdata_q <= (dri_rdata & ~DIV_MASK) |
                                   (DRI_DW'(div_q) << DIV_LSB);
                        fab_q   <= 1'b1;
                    end
                end
                S_WR: begin
                    state_q <= S_WAIT_UNLOCK;
                    tmr_q   <= '0;
                end
                S_WAIT_UNLOCK: begin
                    if (unl_exit) begin
                        state_q <= S_WAIT_LOCK;
                        tmr_q   <= '0;
                    end
                end
                S_WAIT_LOCK: begin
                    if (lock_ok) begin
                        state_q <= S_IDLE;
                        tmr_q   <= '0;
                        cur_q   <= div_q;
                        fab_q   <= 1'b0;
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else if (tmr_q >= T_LOCK) begin
                        state_q <= S_ERR;
                        tmr_q   <= '0;
                        err_q   <= 1'b1;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign cfg_ready  = ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = err_q;
    assign cur_div    = cur_q;
    assign dri_ctrl   = ctrl_q;
    assign dri_wdata  = wdata_q;
    assign dri_arst_n = ~reset;
    assign fab_rst    = fab_q;

endmodule
